instruction_prefetch_queue: RTL and testbench

INSTRUCTION_PREFETCH_QUEUE -- requirements
Module: instruction_prefetch_queue

---
 rtl/fetch_pkg.sv | 8 +
 rtl/byte_queue.sv | 67 ++++++
 rtl/instruction_prefetch_queue.sv | 131 +++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: prefetch FSM states and default geometry.
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQUEST, WAIT, DISCARD} fetch_state_e;

   localparam int DEFAULT_BUS_BYTES   = 4;
   localparam int DEFAULT_QUEUE_DEPTH = 16;
   localparam int DEFAULT_WINDOW      = 10;
endpackage

// File: rtl/byte_queue.sv
// Circular byte FIFO: up to BUS_BYTES pushed and up to WINDOW popped per cycle,
// with the first WINDOW bytes from the head exposed combinationally.
module byte_queue
   import fetch_pkg::*;
#(
   parameter int BUS_BYTES   = DEFAULT_BUS_BYTES,
   parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
   parameter int WINDOW      = DEFAULT_WINDOW
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic [$clog2(BUS_BYTES+1)-1:0]     push_count_i,
   input  logic [8*BUS_BYTES-1:0]             push_data_i,
   input  logic [$clog2(WINDOW+1)-1:0]        pop_count_i,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count_o,
   output logic [WINDOW-1:0][7:0]             window_o
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(QUEUE_DEPTH+1);

   logic [7:0]    mem_q [QUEUE_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      head_d  = head_q + PW'(pop_count_i);
      tail_d  = tail_q + PW'(push_count_i);
      count_d = count_q + CW'(push_count_i) - CW'(pop_count_i);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: bytes beyond count are masked on the window.
   always_ff @(posedge clk_i) begin
      if (!flush_i) begin
         for (int k = 0; k < BUS_BYTES; k++) begin
            if (k < int'(push_count_i)) begin
               mem_q[tail_q + PW'(k)] <= push_data_i[8*k +: 8];
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < WINDOW; gi++) begin : g_window
         assign window_o[gi] = (CW'(gi) < count_q) ? mem_q[head_q + PW'(gi)] : 8'h00;
      end
   endgenerate

   assign count_o = count_q;
endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetcher: fetches aligned bus words into a byte queue and
// presents a WINDOW-byte view to the decoder, with redirect and discard handling.
module instruction_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int BUS_BYTES   = DEFAULT_BUS_BYTES,
   parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
   parameter int WINDOW      = DEFAULT_WINDOW
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            redirect_valid_i,
   input  logic [31:0]                     redirect_address_i,
   output logic                            bus_read_valid_o,
   input  logic                            bus_read_ready_i,
   output logic [31:0]                     bus_read_address_o,
   input  logic [8*BUS_BYTES-1:0]          bus_read_data_i,
   output logic [WINDOW-1:0][7:0]          instruction_o,
   output logic [$clog2(WINDOW+1)-1:0]     instruction_count_o,
   output logic                            instruction_ready_o,
   input  logic                            consume_valid_i,
   input  logic [$clog2(WINDOW+1)-1:0]     consume_count_i
);
   localparam int OW  = $clog2(BUS_BYTES);
   localparam int CW  = $clog2(QUEUE_DEPTH+1);
   localparam int IW  = $clog2(WINDOW+1);
   localparam int PCW = $clog2(BUS_BYTES+1);

   fetch_state_e    state_q, state_d;
   logic [31:0]     fetch_addr_q, fetch_addr_d;
   logic [31:0]     bus_addr_q, bus_addr_d;
   logic [OW-1:0]   skip_q, skip_d;
   logic            bus_valid_q, bus_valid_d;

   logic            flush;
   logic [PCW-1:0]  push_count;
   logic [IW-1:0]   pop_count;
   logic [CW-1:0]   q_count;
   logic            free_ok;

   assign free_ok = (CW'(QUEUE_DEPTH) - q_count) >= CW'(BUS_BYTES);
   assign instruction_count_o = (q_count > CW'(WINDOW)) ? IW'(WINDOW) : IW'(q_count);
   assign instruction_ready_o = (instruction_count_o == IW'(WINDOW));
   assign pop_count = (consume_valid_i && !redirect_valid_i &&
                       consume_count_i <= instruction_count_o) ? consume_count_i : '0;

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      bus_addr_d   = bus_addr_q;
      skip_d       = skip_q;
      bus_valid_d  = bus_valid_q;
      push_count   = '0;
      flush        = 1'b0;
      case (state_q)
         IDLE: ;
         REQUEST: begin
            if (free_ok) begin
               bus_valid_d = 1'b1;
               bus_addr_d  = fetch_addr_q;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (bus_read_ready_i) begin
               push_count   = PCW'(BUS_BYTES) - PCW'(skip_q);
               skip_d       = '0;
               fetch_addr_d = fetch_addr_q + 32'(BUS_BYTES);
               bus_valid_d  = 1'b0;
               state_d      = REQUEST;
            end
         end
         DISCARD: begin
            if (bus_read_ready_i) begin
               bus_valid_d = 1'b0;
               state_d     = REQUEST;
            end
         end
         default: state_d = IDLE;
      endcase
      // A redirect wins over everything; an outstanding read must still complete.
      if (redirect_valid_i) begin
         flush        = 1'b1;
         push_count   = '0;
         fetch_addr_d = {redirect_address_i[31:OW], {OW{1'b0}}};
         skip_d       = redirect_address_i[OW-1:0];
         bus_addr_d   = bus_addr_q;
         if ((state_q == WAIT || state_q == DISCARD) && !bus_read_ready_i) begin
            bus_valid_d = 1'b1;
            state_d     = DISCARD;
         end else begin
            bus_valid_d = 1'b0;
            state_d     = REQUEST;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         fetch_addr_q <= '0;
         bus_addr_q   <= '0;
         skip_q       <= '0;
         bus_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         bus_addr_q   <= bus_addr_d;
         skip_q       <= skip_d;
         bus_valid_q  <= bus_valid_d;
      end
   end

   byte_queue #(
      .BUS_BYTES   (BUS_BYTES),
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .WINDOW      (WINDOW)
   ) u_queue (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush),
      .push_count_i (push_count),
      .push_data_i  (bus_read_data_i >> {skip_q, 3'b000}),
      .pop_count_i  (pop_count),
      .count_o      (q_count),
      .window_o     (instruction_o)
   );

   assign bus_read_valid_o   = bus_valid_q;
   assign bus_read_address_o = bus_addr_q;
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: byte-queue reference model, directed
// scenarios with literal expectations, then a randomized run.
module tb_instruction_prefetch_queue;
   localparam int BB = 4;
   localparam int QD = 16;
   localparam int W  = 10;
   localparam int IW = $clog2(W+1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              redirect;
   logic [31:0]       raddr;
   logic              bus_valid;
   logic              bus_ready;
   logic [31:0]       bus_addr;
   logic [8*BB-1:0]   bus_data;
   logic [W-1:0][7:0] instr;
   logic [IW-1:0]     icount;
   logic              iready;
   logic              cvalid;
   logic [IW-1:0]     ccount;

   always #5 clk = ~clk;

   instruction_prefetch_queue #(.BUS_BYTES(BB), .QUEUE_DEPTH(QD), .WINDOW(W)) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .redirect_valid_i    (redirect),
      .redirect_address_i  (raddr),
      .bus_read_valid_o    (bus_valid),
      .bus_read_ready_i    (bus_ready),
      .bus_read_address_o  (bus_addr),
      .bus_read_data_i     (bus_data),
      .instruction_o       (instr),
      .instruction_count_o (icount),
      .instruction_ready_o (iready),
      .consume_valid_i     (cvalid),
      .consume_count_i     (ccount)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: queued bytes plus the outstanding-read bookkeeping.
   logic [7:0]  mq[$];
   bit          m_active, m_valid, m_discard;
   logic [31:0] m_addr, m_fetch;
   int          m_skip;
   int          lat = 2;
   int          wcnt = 0;
   bit          ready_now = 0;
   bit          rand_lat = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_active = 0; m_valid = 0; m_discard = 0;
      m_addr = '0; m_fetch = '0; m_skip = 0;
   endtask

   task automatic model_step();
      int cnt = mq.size();
      int ic  = (cnt > W) ? W : cnt;
      if (redirect) begin
         mq.delete();
         m_fetch  = raddr & ~32'(BB-1);
         m_skip   = int'(raddr & 32'(BB-1));
         m_active = 1;
         if (m_valid && !bus_ready) m_discard = 1;
         else begin m_valid = 0; m_discard = 0; end
      end else begin
         if (cvalid && int'(ccount) <= ic)
            for (int k = 0; k < int'(ccount); k++) void'(mq.pop_front());
         if (m_valid) begin
            if (bus_ready) begin
               if (!m_discard) begin
                  for (int k = m_skip; k < BB; k++) mq.push_back(8'(m_fetch + 32'(k)));
                  m_fetch = m_fetch + BB;
                  m_skip  = 0;
               end
               m_discard = 0;
               m_valid   = 0;
            end
         end else if (m_active && (QD - cnt) >= BB) begin
            m_valid = 1;
            m_addr  = m_fetch;
         end
      end
   endtask

   task automatic compare_all();
      int sz = mq.size();
      check("bus_valid", {31'b0, bus_valid}, {31'b0, m_valid});
      if (m_valid) check("bus_addr", bus_addr, m_addr);
      check("icount", 32'(icount), 32'((sz > W) ? W : sz));
      check("iready", {31'b0, iready}, {31'b0, sz >= W});
      for (int i = 0; i < W; i++)
         check($sformatf("instr[%0d]", i), 32'(instr[i]), (i < sz) ? 32'(mq[i]) : 32'h0);
   endtask

   task automatic tick();
      if (rand_lat && wcnt == 0) lat = $urandom_range(0, 3);
      if (m_valid && rst_n) begin
         bus_ready = (wcnt >= lat) || ready_now;
         wcnt++;
      end else begin
         bus_ready = 0;
         wcnt = 0;
      end
      for (int k = 0; k < BB; k++) bus_data[8*k +: 8] = 8'(m_addr + 32'(k));
      if (!rst_n) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      compare_all();
      ready_now = 0;
   endtask

   task automatic run_until(input bit on_valid, input int target, input string name);
      for (int i = 0; i < 60; i++) begin
         if (on_valid ? (int'(m_valid) == target) : (mq.size() >= target)) return;
         tick();
      end
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout waiting, got none required %0d", name, target);
   endtask

   task automatic do_reset();
      rst_n = 0; tick(); rst_n = 1; tick();
   endtask

   task automatic pulse_redirect(input logic [31:0] a);
      redirect = 1; raddr = a; tick(); redirect = 0;
   endtask

   initial begin
      rst_n = 0; redirect = 0; raddr = '0; bus_ready = 0; bus_data = '0;
      cvalid = 0; ccount = '0;
      model_reset();
      tick(); tick();
      check("reset_valid", {31'b0, bus_valid}, 32'h0);
      check("reset_addr", bus_addr, 32'h0);
      check("reset_icount", 32'(icount), 32'h0);
      rst_n = 1; tick();

      // Fill from 0x1000, then full-queue flow control.
      pulse_redirect(32'h1000);
      tick();
      check("A_first_valid", {31'b0, bus_valid}, 32'h1);
      check("A_first_addr", bus_addr, 32'h1000);
      repeat (40) tick();
      check("A_instr0", 32'(instr[0]), 32'h00);
      check("A_instr9", 32'(instr[9]), 32'h09);
      check("A_ready", {31'b0, iready}, 32'h1);
      check("A_idle", {31'b0, bus_valid}, 32'h0);
      cvalid = 1; ccount = 3; tick(); cvalid = 0;
      check("F_no_req13", {31'b0, bus_valid}, 32'h0);
      check("F_icount13", 32'(icount), 32'd10);
      tick();
      check("F_still_idle", {31'b0, bus_valid}, 32'h0);
      cvalid = 1; ccount = 1; tick(); cvalid = 0;
      check("F_same_cycle", {31'b0, bus_valid}, 32'h0);
      tick();
      check("F_req12", {31'b0, bus_valid}, 32'h1);
      check("F_req12_addr", bus_addr, 32'h1010);

      // Unaligned redirect skips leading bytes.
      do_reset();
      pulse_redirect(32'h1003);
      tick();
      check("B_addr0", bus_addr, 32'h1000);
      run_until(0, 1, "B_push");
      check("B_instr0", 32'(instr[0]), 32'h03);
      check("B_instr1_zero", 32'(instr[1]), 32'h00);
      check("B_icount", 32'(icount), 32'd1);
      run_until(1, 1, "B_req2");
      check("B_addr1", bus_addr, 32'h1004);

      // Oversized consume ignored; push and consume in the same cycle.
      do_reset();
      pulse_redirect(32'h1001);
      run_until(0, 3, "E_fill3");
      check("E_icount3", 32'(icount), 32'd3);
      lat = 100;
      run_until(1, 1, "E_req");
      cvalid = 1; ccount = 5; tick(); cvalid = 0;
      check("E_ignored", 32'(icount), 32'd3);
      cvalid = 1; ccount = 2; ready_now = 1; tick(); cvalid = 0;
      check("E_icount5", 32'(icount), 32'd5);
      check("E_instr0", 32'(instr[0]), 32'h03);
      check("E_instr4", 32'(instr[4]), 32'h07);

      // Redirect during an outstanding read.
      do_reset();
      pulse_redirect(32'h1008);
      run_until(1, 1, "C_req");
      check("C_addr_old", bus_addr, 32'h1008);
      pulse_redirect(32'h2000);
      check("C_held_valid", {31'b0, bus_valid}, 32'h1);
      check("C_held_addr", bus_addr, 32'h1008);
      repeat (3) tick();
      check("C_still_held", {31'b0, bus_valid}, 32'h1);
      ready_now = 1; tick();
      check("C_dropped_valid", {31'b0, bus_valid}, 32'h0);
      check("C_dropped_count", 32'(icount), 32'h0);
      lat = 1;
      run_until(1, 1, "C_new_req");
      check("C_new_addr", bus_addr, 32'h2000);
      run_until(0, 4, "C_new_data");
      check("C_instr0", 32'(instr[0]), 32'h00);
      check("C_instr3", 32'(instr[3]), 32'h03);

      // Asynchronous reset mid-transaction.
      do_reset();
      lat = 100;
      pulse_redirect(32'h3000);
      run_until(1, 1, "D_req");
      check("D_addr", bus_addr, 32'h3000);
      rst_n = 0; model_reset();
      #1;
      check("D_async_valid", {31'b0, bus_valid}, 32'h0);
      check("D_async_addr", bus_addr, 32'h0);
      check("D_async_count", 32'(icount), 32'h0);
      tick();
      rst_n = 1; lat = 0;
      repeat (8) tick();
      check("D_no_req", {31'b0, bus_valid}, 32'h0);

      // Fetch address wraps past 2^32.
      do_reset();
      pulse_redirect(32'hFFFF_FFFA);
      run_until(0, 10, "G_fill");
      check("G_instr0", 32'(instr[0]), 32'hFA);
      check("G_instr6", 32'(instr[6]), 32'h00);

      // Randomized traffic.
      do_reset();
      rand_lat = 1;
      pulse_redirect($urandom());
      for (int c = 0; c < 3000; c++) begin
         redirect = ($urandom_range(0, 99) < 2);
         raddr    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom();
         cvalid   = ($urandom_range(0, 99) < ((c % 600 < 300) ? 60 : 25));
         ccount   = IW'($urandom_range(1, W));
         tick();
      end
      redirect = 0; cvalid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
